// File: rtl/tx_mac_interface_pkg.sv
// Shared definitions for the MAC transmit-side buffer reader.
package tx_mac_interface_pkg;

  // Buffer address MSB; addresses are [BF:0]
  localparam int BF = 7;
  localparam int AW = BF + 1;

  // Header word layout: byte count lives in the top 16 bits
  localparam int TX_LEN_HI = 63;
  localparam int TX_LEN_LO = 48;

  localparam int MAX_FRAME_BYTES_DEF = 9018;

  // One-hot reader states
  typedef enum logic [7:0] {
    S_IDLE     = 8'b0000_0001,
    S_HDR      = 8'b0000_0010,
    S_FILL1    = 8'b0000_0100,
    S_FILL2    = 8'b0000_1000,
    S_LOAD     = 8'b0001_0000,
    S_WAIT_ACK = 8'b0010_0000,
    S_STREAM   = 8'b0100_0000,
    S_DONE     = 8'b1000_0000
  } tx_state_e;

  // ceil(len/8) as a 13-bit word count
  function automatic logic [12:0] word_count(input logic [15:0] len);
    logic [16:0] s;
    s = {1'b0, len} + 17'd7;
    return s[15:3];
  endfunction

  // Byte-valid mask for the final word of a frame
  function automatic logic [7:0] last_mask(input logic [2:0] len_lsb);
    if (len_lsb == 3'd0) return 8'hFF;
    return (8'h01 << len_lsb) - 8'h01;
  endfunction

endpackage

// File: rtl/tx_mac_interface.sv
// Reads length-prefixed frames from the ring buffer and presents them on the
// 64-bit MAC client Tx interface. A frame is only started once it is fully
// committed by the writer, so underrun can never happen.
module tx_mac_interface
  import tx_mac_interface_pkg::*;
#(
  parameter int MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tx_enable,
  output logic [63:0]   tx_data,
  output logic [7:0]    tx_data_valid,
  output logic          tx_start,
  output logic          tx_underrun,
  input  logic          tx_ack,
  output logic [AW-1:0] rd_addr,
  input  logic [63:0]   rd_data,
  output logic [AW-1:0] commited_rd_address,
  input  logic [AW-1:0] commited_wr_address,
  output logic [31:0]   frames_sent_counter,
  output logic [31:0]   bad_header_counter
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);

  tx_state_e     r_state, w_next;
  logic [AW-1:0] r_hdr;        // header slot of frame in flight
  logic [12:0]   r_nw;         // words in frame
  logic [12:0]   r_idx;        // 1-based index of word on tx_data
  logic [7:0]    r_mask;       // valid mask of the last word
  logic [63:0]   r_next_word;  // word2, parked while waiting for tx_ack

  logic [15:0]   w_len;
  logic [12:0]   w_hdr_nw;
  logic          w_bad;
  logic          w_pending;
  logic          w_go;

  assign w_len     = rd_data[TX_LEN_HI:TX_LEN_LO];
  assign w_hdr_nw  = word_count(w_len);
  assign w_bad     = (w_len == 16'd0) || (w_len > MAX_LEN);
  assign w_pending = commited_wr_address != commited_rd_address;
  assign w_go      = tx_enable && w_pending;

  assign tx_underrun = 1'b0;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_go) w_next = S_HDR;
      S_HDR:      w_next = S_FILL1;
      S_FILL1:    w_next = w_bad ? S_IDLE : S_FILL2;
      S_FILL2:    w_next = S_LOAD;
      S_LOAD:     w_next = S_WAIT_ACK;
      S_WAIT_ACK: if (tx_ack) w_next = (r_nw == 13'd1) ? S_DONE : S_STREAM;
      S_STREAM:   if (r_idx == r_nw) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Read pipeline, MAC-side outputs, commit pointer and counters.
  // rd_data trails rd_addr by one cycle, so while streaming the word just
  // returned is always the one that goes out next.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_data             <= '0;
      tx_data_valid       <= '0;
      tx_start            <= 1'b0;
      rd_addr             <= '0;
      commited_rd_address <= '0;
      frames_sent_counter <= '0;
      bad_header_counter  <= '0;
      r_hdr               <= '0;
      r_nw                <= '0;
      r_idx               <= '0;
      r_mask              <= '0;
      r_next_word         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          tx_data_valid <= '0;
          if (w_go) begin
            rd_addr <= commited_rd_address;
            r_hdr   <= commited_rd_address;
          end
        end
        S_HDR: rd_addr <= rd_addr + 1'b1;
        S_FILL1: begin
          // header word is on rd_data now
          r_nw   <= w_hdr_nw;
          r_mask <= last_mask(w_len[2:0]);
          if (w_bad) begin
            bad_header_counter  <= bad_header_counter + 32'd1;
            commited_rd_address <= (w_len == 16'd0) ? r_hdr + 1'b1
                                                     : r_hdr + AW'(w_hdr_nw) + 1'b1;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        S_FILL2: begin
          tx_data <= rd_data;
          rd_addr <= rd_addr + 1'b1;
        end
        S_LOAD: begin
          r_next_word   <= rd_data;
          tx_start      <= 1'b1;
          tx_data_valid <= (r_nw == 13'd1) ? r_mask : 8'hFF;
        end
        S_WAIT_ACK: begin
          if (tx_ack) begin
            tx_start <= 1'b0;
            if (r_nw == 13'd1) begin
              tx_data_valid <= '0;
            end else begin
              tx_data       <= r_next_word;
              tx_data_valid <= (r_nw == 13'd2) ? r_mask : 8'hFF;
              r_idx         <= 13'd2;
              rd_addr       <= rd_addr + 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (r_idx == r_nw) begin
            tx_data_valid <= '0;
          end else begin
            tx_data       <= rd_data;
            tx_data_valid <= (r_idx + 13'd1 == r_nw) ? r_mask : 8'hFF;
            r_idx         <= r_idx + 13'd1;
            rd_addr       <= rd_addr + 1'b1;
          end
        end
        S_DONE: begin
          commited_rd_address <= r_hdr + AW'(r_nw) + 1'b1;
          frames_sent_counter <= frames_sent_counter + 32'd1;
        end
        default: tx_data_valid <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_mac_interface.sv
// Directed bench: ring-buffer model, tx_ack responder and a scoreboard of
// expected MAC words filled when frames are written into the buffer.
module tb_tx_mac_interface;
  import tx_mac_interface_pkg::*;

  localparam int SLOTS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tx_enable;
  logic [63:0]   tx_data;
  logic [7:0]    tx_data_valid;
  logic          tx_start;
  logic          tx_underrun;
  logic          tx_ack = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_data = '0;
  logic [AW-1:0] commited_rd_address;
  logic [AW-1:0] commited_wr_address;
  logic [31:0]   frames_sent_counter;
  logic [31:0]   bad_header_counter;

  tx_mac_interface dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .tx_enable           (tx_enable),
    .tx_data             (tx_data),
    .tx_data_valid       (tx_data_valid),
    .tx_start            (tx_start),
    .tx_underrun         (tx_underrun),
    .tx_ack              (tx_ack),
    .rd_addr             (rd_addr),
    .rd_data             (rd_data),
    .commited_rd_address (commited_rd_address),
    .commited_wr_address (commited_wr_address),
    .frames_sent_counter (frames_sent_counter),
    .bad_header_counter  (bad_header_counter)
  );

  always #5 clk = ~clk;

  // Buffer model: one-cycle read latency
  logic [63:0] mem [SLOTS];
  always @(posedge clk) rd_data <= mem[rd_addr];

  typedef struct {
    logic [63:0] d;
    logic [7:0]  v;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   ack_delay = 1;
  int   scnt = 0;
  int   starts = 0;
  int   words_seen = 0;
  int   idle_cnt = 100;
  int   cur_stall = 0;
  int   stall_cycles = 0;
  bit   in_frame = 0;
  bit   prev_start = 0;
  bit   mon_en = 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Writes a frame into the ring and queues the words the MAC should see
  task automatic put_frame(input int h, input int len, output int nh);
    int   n, bytes;
    exp_t e;
    n = (len + 7) / 8;
    mem[h % SLOTS] = {16'(len), 48'hDEAD_BEEF_0123};
    for (int k = 0; k < n; k++) begin
      e.d = {$urandom, $urandom};
      mem[(h + 1 + k) % SLOTS] = e.d;
      e.last = (k == n - 1);
      e.v = 8'hFF;
      if (e.last) begin
        bytes = len - 8 * (n - 1);
        e.v = '0;
        for (int b = 0; b < bytes; b++) e.v[b] = 1'b1;
      end
      exp_q.push_back(e);
    end
    nh = (h + n + 1) % SLOTS;
  endtask

  task automatic wait_sent(input int target, input int budget);
    int n = 0;
    while (frames_sent_counter != 32'(target) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check("frames_sent", frames_sent_counter, 64'(target));
  endtask

  // tx_ack responder plus MAC-side monitor
  always @(negedge clk) begin
    exp_t e;
    if (tx_start) begin
      tx_ack = (scnt == ack_delay);
      scnt++;
    end else begin
      tx_ack = 1'b0;
      scnt = 0;
    end
    if (mon_en) begin
      if (tx_start && !prev_start) begin
        starts++;
        check("interframe_gap_ok", 64'(idle_cnt >= 2), 64'd1);
      end
      if (tx_data_valid != 8'h00) idle_cnt = 0;
      else idle_cnt++;
      if (tx_data_valid != 8'h00 && (!tx_start || tx_ack)) begin
        if (tx_ack) begin
          stall_cycles = cur_stall;
          cur_stall = 0;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(tx_data_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("word_data", tx_data, e.d);
          check("word_valid", 64'(tx_data_valid), 64'(e.v));
          in_frame = !e.last;
          words_seen++;
        end
      end else if (tx_start && !tx_ack) begin
        cur_stall++;
        if (exp_q.size() != 0) begin
          check("stall_data", tx_data, exp_q[0].d);
          check("stall_valid", 64'(tx_data_valid), 64'(exp_q[0].v));
        end
      end else if (in_frame) begin
        check("stream_gap", 64'(tx_data_valid), 64'hFF);
        in_frame = 0;
      end
    end
    prev_start = tx_start;
  end

  initial begin
    int h, n, s0, base;
    reset_n = 1'b0;
    tx_enable = 1'b0;
    commited_wr_address = '0;
    for (int i = 0; i < SLOTS; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_data", tx_data, 64'd0);
    check("rst_valid", 64'(tx_data_valid), 64'd0);
    check("rst_start", 64'(tx_start), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_commit", 64'(commited_rd_address), 64'd0);
    check("rst_sent", 64'(frames_sent_counter), 64'd0);
    check("rst_badhdr", 64'(bad_header_counter), 64'd0);
    check("underrun", 64'(tx_underrun), 64'd0);
    reset_n = 1'b1;
    tx_enable = 1'b1;

    // 1: 64-byte frame at slot 0, start latency from IDLE detection
    put_frame(0, 64, h);
    @(posedge clk); #1;
    commited_wr_address = AW'(h);
    n = 0;
    while (!tx_start && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("t1_start_latency", 64'(n), 64'd5);
    check("t1_rd_addr_hold", 64'(rd_addr), 64'd3);
    wait_sent(1, 100);
    check("t1_commit", 64'(commited_rd_address), 64'd9);

    // 2: 61-byte then 1-byte frame queued together
    put_frame(9, 61, h);
    put_frame(h, 1, h);
    commited_wr_address = AW'(h);
    wait_sent(3, 200);
    check("t2_commit", 64'(commited_rd_address), 64'd20);
    check("t2_starts", 64'(starts), 64'd3);
    check("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // 3: tx_ack held off for 20 cycles
    ack_delay = 20;
    put_frame(20, 64, h);
    commited_wr_address = AW'(h);
    wait_sent(4, 200);
    check("t3_stall_cycles", 64'(stall_cycles), 64'd20);
    check("t3_commit", 64'(commited_rd_address), 64'd29);
    ack_delay = 1;

    // 5: zero-length header is skipped, then a long valid frame
    s0 = starts;
    mem[29] = {16'd0, 48'h1234_5678_9ABC};
    commited_wr_address = AW'(30);
    repeat (15) @(posedge clk);
    #1;
    check("t5_badhdr", 64'(bad_header_counter), 64'd1);
    check("t5_commit", 64'(commited_rd_address), 64'd30);
    check("t5_no_start", 64'(starts), 64'(s0));
    put_frame(30, 1776, h);
    commited_wr_address = AW'(h);
    wait_sent(5, 600);
    check("t5_commit2", 64'(commited_rd_address), 64'd253);

    // 4: frame wrapping past the top slot
    put_frame(253, 40, h);
    commited_wr_address = AW'(h);
    wait_sent(6, 100);
    check("t4_commit", 64'(commited_rd_address), 64'd3);
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // oversized header skips H+N+1 = 3+1128+1 mod 256 = 108
    mem[3] = {16'd9019, 48'h0};
    commited_wr_address = AW'(108);
    repeat (15) @(posedge clk);
    #1;
    check("big_badhdr", 64'(bad_header_counter), 64'd2);
    check("big_commit", 64'(commited_rd_address), 64'd108);

    // 6: reset while word 4 is on the bus
    put_frame(108, 64, h);
    commited_wr_address = AW'(h);
    base = words_seen;
    n = 0;
    while (words_seen != base + 3 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("t6_reached_word4", 64'(words_seen), 64'(base + 3));
    mon_en = 0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("t6_valid", 64'(tx_data_valid), 64'd0);
    check("t6_data", tx_data, 64'd0);
    check("t6_start", 64'(tx_start), 64'd0);
    check("t6_commit", 64'(commited_rd_address), 64'd0);
    check("t6_sent", 64'(frames_sent_counter), 64'd0);
    check("t6_badhdr", 64'(bad_header_counter), 64'd0);
    commited_wr_address = '0;
    exp_q.delete();
    in_frame = 0;
    reset_n = 1'b1;
    mon_en = 1;

    // tx_enable dropped after a frame starts: it completes, nothing new starts
    put_frame(0, 24, h);
    commited_wr_address = AW'(h);
    s0 = starts;
    n = 0;
    while (starts == s0 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check("t6b_started", 64'(starts), 64'(s0 + 1));
    tx_enable = 1'b0;
    put_frame(4, 16, h);
    commited_wr_address = AW'(h);
    repeat (40) @(posedge clk);
    #1;
    check("t6b_sent_while_low", 64'(frames_sent_counter), 64'd1);
    check("t6b_pending_words", 64'(exp_q.size()), 64'd2);
    check("t6b_no_new_start", 64'(starts), 64'(s0 + 1));
    tx_enable = 1'b1;
    wait_sent(2, 100);
    check("t6b_commit", 64'(commited_rd_address), 64'd7);
    check("t6b_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
